mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed memory port between Y86 instruction fetch and data access.
// Define Y86_ARB_RR_EN for round-robin tie-breaking; otherwise data always wins over fetch.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned INST_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  output logic              if_ack_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_stall_o,
  // data requester
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  // memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch0,
    StFetch1,
    StData,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                owner_data_q;  // 1: data stage owns the current sequence
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic [DATA_W-1:0]   beat0_q;
  logic [INST_W-1:0]   inst_q;
  logic [DATA_W-1:0]   rdata_q;

  logic data_pend;
  logic fetch_pend;
  logic grant_data;
  logic grant_fetch;

  assign data_pend  = dm_read_i | dm_write_i;
  assign fetch_pend = if_req_i;

`ifdef Y86_ARB_RR_EN
  logic last_data_q;  // reset to "fetch" so data wins the first tie

  assign grant_data = data_pend & (~fetch_pend | ~last_data_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data_q <= 1'b0;
    end else if (state_q == StIdle && (grant_data || grant_fetch)) begin
      last_data_q <= grant_data;
    end
  end
`else
  assign grant_data = data_pend;
`endif

  assign grant_fetch = fetch_pend & ~grant_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant_data) begin
          state_d = StData;
        end else if (grant_fetch) begin
          state_d = StFetch0;
        end
      end
      StFetch0: if (mem_ack_i) state_d = StFetch1;
      StFetch1: if (mem_ack_i) state_d = StDone;
      StData:   if (mem_ack_i) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture: the memory side only ever sees these latched copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_data_q <= 1'b0;
      pc_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
    end else if (state_q == StIdle) begin
      if (grant_data) begin
        owner_data_q <= 1'b1;
        addr_q       <= dm_addr_i;
        wdata_q      <= dm_wdata_i;
        we_q         <= dm_write_i;
      end else if (grant_fetch) begin
        owner_data_q <= 1'b0;
        pc_q         <= if_pc_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat0_q <= '0;
      inst_q  <= '0;
      rdata_q <= '0;
    end else if (mem_ack_i) begin
      case (state_q)
        StFetch0: beat0_q <= mem_rdata_i;
        // Byte at pc lands in the top byte; pc+5 in the bottom byte.
        StFetch1: inst_q <= {beat0_q[7:0], beat0_q[15:8], beat0_q[23:16], beat0_q[31:24],
                             mem_rdata_i[7:0], mem_rdata_i[15:8]};
        StData:   if (!we_q) rdata_q <= mem_rdata_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      StFetch0: begin
        mem_req_o  = 1'b1;
        mem_addr_o = pc_q;
      end
      StFetch1: begin
        mem_req_o  = 1'b1;
        mem_addr_o = pc_q + ADDR_W'(4);
      end
      StData: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
      end
      default: ;
    endcase
  end

  assign if_ack_o   = (state_q == StDone) & ~owner_data_q;
  assign dm_ack_o   = (state_q == StDone) & owner_data_q;
  assign if_inst_o  = inst_q;
  assign dm_rdata_o = rdata_q;
  assign if_stall_o = if_req_i & ~if_ack_o;
  assign dm_stall_o = (dm_read_i | dm_write_i) & ~dm_ack_o;

  ack_exclusive: assert property (@(posedge clk) disable iff (rst) !(if_ack_o && dm_ack_o));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, a byte-memory model with
// configurable wait states, and a monitor that checks every ack against queued expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_pc_i;
  logic        if_ack_o;
  logic [47:0] if_inst_o;
  logic        if_stall_o;
  logic        dm_read_i;
  logic        dm_write_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        dm_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .INST_W(48)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_pc_i    (if_pc_i),
    .if_ack_o   (if_ack_o),
    .if_inst_o  (if_inst_o),
    .if_stall_o (if_stall_o),
    .dm_read_i  (dm_read_i),
    .dm_write_i (dm_write_i),
    .dm_addr_i  (dm_addr_i),
    .dm_wdata_i (dm_wdata_i),
    .dm_ack_o   (dm_ack_o),
    .dm_rdata_o (dm_rdata_o),
    .dm_stall_o (dm_stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ack_i  (mem_ack_i)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got no response, required one (cycle %0d)", name, cyc);
  endtask

  // Scoreboard of expected acks (cyc < 0: timing not checked) and expected memory writes.
  typedef struct {
    logic        is_data;
    logic        chk_data;
    logic [47:0] data;
    int          cyc;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  exp_t sb[$];
  wr_t  wq[$];

  task automatic expect_ack(input logic is_data, input logic chk, input logic [47:0] d,
                            input int c);
    exp_t e;
    e.is_data  = is_data;
    e.chk_data = chk;
    e.data     = d;
    e.cyc      = c;
    sb.push_back(e);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (if_ack_o || dm_ack_o) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {if_ack_o, dm_ack_o}, 2'b00);
      end else begin
        e = sb.pop_front();
        check("ack_owner", {if_ack_o, dm_ack_o}, e.is_data ? 2'b01 : 2'b10);
        if (e.chk_data) begin
          if (e.is_data) check("dm_rdata", dm_rdata_o, e.data);
          else           check("if_inst", if_inst_o, e.data);
        end
        if (e.cyc >= 0) check("ack_cycle", cyc, e.cyc);
      end
    end
  end

  // Read-only byte memory; writes are checked against the expected-write queue.
  logic [7:0]  mem [0:4095];
  int unsigned wait_cfg = 0;
  int unsigned wcnt = 0;
  logic        model_ack = 1'b0;
  logic        force_ack = 1'b0;

  assign mem_ack_i = model_ack | force_ack;

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    mem[a[11:0]] = v;
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b;
    for (int i = 0; i < 4; i++) begin
      b = a + 32'(i);
      w[8*i +: 8] = mem[b[11:0]];
    end
    return w;
  endfunction

  always @(negedge clk) begin : mem_model
    wr_t w;
    if (mem_req_o && wcnt == wait_cfg) begin
      model_ack   <= 1'b1;
      mem_rdata_i <= rd_word(mem_addr_o);
      wcnt        <= 0;
      if (mem_we_o) begin
        if (wq.size() == 0) begin
          check("unexpected_write", {mem_addr_o, mem_wdata_o}, '0);
        end else begin
          w = wq.pop_front();
          check("write_addr", mem_addr_o, w.addr);
          check("write_data", mem_wdata_o, w.data);
        end
      end
    end else if (mem_req_o) begin
      model_ack <= 1'b0;
      wcnt      <= wcnt + 1;
    end else begin
      model_ack <= 1'b0;
      wcnt      <= 0;
    end
  end

  task automatic wait_if_ack(input int limit);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (if_ack_o) begin
        check("if_stall_at_ack", if_stall_o, 1'b0);
        done = 1;
      end else begin
        check("if_stall_wait", if_stall_o, 1'b1);
        n++;
        if (n >= limit) begin
          fail("if_ack_timeout");
          done = 1;
        end
      end
    end
  endtask

  task automatic wait_dm_ack(input int limit);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (dm_ack_o) begin
        check("dm_stall_at_ack", dm_stall_o, 1'b0);
        done = 1;
      end else begin
        check("dm_stall_wait", dm_stall_o, 1'b1);
        n++;
        if (n >= limit) begin
          fail("dm_ack_timeout");
          done = 1;
        end
      end
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input bit keep);
    if_pc_i  = pc;
    if_req_i = 1'b1;
    wait_if_ack(60);
    if (!keep) if_req_i = 1'b0;
  endtask

  task automatic do_data(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit keep);
    dm_read_i  = rd;
    dm_write_i = wr;
    dm_addr_i  = a;
    dm_wdata_i = d;
    wait_dm_ack(60);
    if (!keep) begin
      dm_read_i  = 1'b0;
      dm_write_i = 1'b0;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'hA5;
    poke(32'h100, 8'hEF); poke(32'h101, 8'hBE); poke(32'h102, 8'hAD); poke(32'h103, 8'hDE);
    poke(32'h204, 8'hEF); poke(32'h205, 8'hCD); poke(32'h206, 8'hAB); poke(32'h207, 8'h89);
    poke(32'h010, 8'h60); poke(32'h011, 8'h00); poke(32'h012, 8'h11);
    poke(32'h013, 8'h22); poke(32'h014, 8'h33); poke(32'h015, 8'h44);
    poke(32'h020, 8'h10); poke(32'h021, 8'h20); poke(32'h022, 8'h30);
    poke(32'h023, 8'h40); poke(32'h024, 8'h50); poke(32'h025, 8'h60);
    // 0x0FFFFFFE..0x10000003 alias 0xFFE..0x003 in the model
    poke(32'hFFE, 8'h30); poke(32'hFFF, 8'hF0); poke(32'h000, 8'h01);
    poke(32'h001, 8'h00); poke(32'h002, 8'h00); poke(32'h003, 8'h00);

    rst        = 1'b1;
    if_req_i   = 1'b0;
    if_pc_i    = '0;
    dm_read_i  = 1'b0;
    dm_write_i = 1'b0;
    dm_addr_i  = '0;
    dm_wdata_i = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {if_ack_o, if_inst_o, if_stall_o, dm_ack_o, dm_rdata_o, dm_stall_o,
                            mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero-wait read
    @(posedge clk); #1;
    expect_ack(1'b1, 1'b1, 48'hDEADBEEF, cyc + 2);
    dm_read_i = 1'b1;
    dm_addr_i = 32'h100;
    @(negedge clk);
    check("rd_req_cycle0", mem_req_o, 1'b0);
    @(negedge clk);
    check("rd_req_cycle1", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 32'h100});
    wait_dm_ack(20);
    dm_read_i = 1'b0;

    // Fetch across a 0x10000000 boundary
    @(posedge clk); #1;
    expect_ack(1'b0, 1'b1, 48'h30F001000000, cyc + 3);
    if_pc_i  = 32'h0FFFFFFE;
    if_req_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("fetch_beat0_addr", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 32'h0FFFFFFE});
    @(negedge clk);
    check("fetch_beat1_addr", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 32'h10000002});
    wait_if_ack(20);
    if_req_i = 1'b0;

    // Fetch whose second beat wraps the address space
    poke(32'hFFE, 8'h61); poke(32'hFFF, 8'h62); poke(32'h000, 8'h63);
    poke(32'h001, 8'h64); poke(32'h002, 8'h65); poke(32'h003, 8'h66);
    @(posedge clk); #1;
    expect_ack(1'b0, 1'b1, 48'h616263646566, cyc + 3);
    if_pc_i  = 32'hFFFFFFFE;
    if_req_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("wrap_beat1_addr", mem_addr_o, 32'h00000002);
    wait_if_ack(20);
    if_req_i = 1'b0;

    // Simultaneous write and fetch: last grant was fetch, so data wins in both modes
    @(posedge clk); #1;
    expect_ack(1'b1, 1'b0, '0, cyc + 2);
    expect_ack(1'b0, 1'b1, 48'h600011223344, cyc + 6);
    expect_write(32'h200, 32'h12345678);
    fork
      do_data(1'b0, 1'b1, 32'h200, 32'h12345678, 1'b0);
      do_fetch(32'h10, 1'b0);
    join

    // Back-to-back requests from both stages
    @(posedge clk); #1;
`ifdef Y86_ARB_RR_EN
    expect_ack(1'b1, 1'b0, '0, -1);
    expect_ack(1'b0, 1'b1, 48'h600011223344, -1);
    expect_ack(1'b1, 1'b0, '0, -1);
    expect_ack(1'b0, 1'b1, 48'h102030405060, -1);
    expect_ack(1'b1, 1'b0, '0, -1);
`else
    expect_ack(1'b1, 1'b0, '0, -1);
    expect_ack(1'b1, 1'b0, '0, -1);
    expect_ack(1'b1, 1'b0, '0, -1);
    expect_ack(1'b0, 1'b1, 48'h600011223344, -1);
    expect_ack(1'b0, 1'b1, 48'h102030405060, -1);
`endif
    expect_write(32'h300, 32'hA0000001);
    expect_write(32'h304, 32'hA0000002);
    expect_write(32'h308, 32'hA0000003);
    fork
      begin
        do_data(1'b0, 1'b1, 32'h300, 32'hA0000001, 1'b1);
        @(posedge clk); #1;
        do_data(1'b0, 1'b1, 32'h304, 32'hA0000002, 1'b1);
        @(posedge clk); #1;
        do_data(1'b0, 1'b1, 32'h308, 32'hA0000003, 1'b0);
      end
      begin
        do_fetch(32'h10, 1'b1);
        @(posedge clk); #1;
        do_fetch(32'h20, 1'b0);
      end
    join

    // Three wait cycles per beat; data request arrives during FETCH0 and must wait
    wait_cfg = 3;
    @(posedge clk); #1;
    expect_ack(1'b0, 1'b1, 48'h102030405060, cyc + 9);
    expect_ack(1'b1, 1'b1, 48'h89ABCDEF, cyc + 15);
    fork
      do_fetch(32'h20, 1'b0);
      begin
        @(negedge clk);
        @(negedge clk);
        do_data(1'b1, 1'b0, 32'h204, 32'h0, 1'b0);
      end
    join

    // Reset in FETCH1 with a late memory ack
    wait_cfg = 1;
    @(posedge clk); #1;
    if_pc_i  = 32'h10;
    if_req_i = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_reset_in_fetch1", {mem_req_o, mem_addr_o}, {1'b1, 32'h14});
    rst      = 1'b1;
    if_req_i = 1'b0;
    #1;
    check("async_reset_req", mem_req_o, 1'b0);
    @(posedge clk); #1;
    rst       = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {if_ack_o, if_inst_o, if_stall_o, dm_ack_o, dm_rdata_o,
                                 dm_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {mem_req_o, if_ack_o, dm_ack_o}, 3'b000);

    // Read with two wait cycles
    wait_cfg = 2;
    @(posedge clk); #1;
    expect_ack(1'b1, 1'b1, 48'h89ABCDEF, cyc + 4);
    do_data(1'b1, 1'b0, 32'h204, 32'h0, 1'b0);

    // Read and write both high is a write
    wait_cfg = 0;
    @(posedge clk); #1;
    expect_ack(1'b1, 1'b0, '0, cyc + 2);
    expect_write(32'h400, 32'hCAFEF00D);
    do_data(1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0);

    repeat (4) @(negedge clk);
    check("acks_outstanding", sb.size(), 0);
    check("writes_outstanding", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
